uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD_RATE, default 9600, meaning line bit rate; BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE clocks per bit.
REQ-003 SHALL provide parameter DATA_BIT, default 8, meaning data bits per frame (5..8).
REQ-004 SHALL provide parameter STOP_BIT, default 1, meaning stop bits per frame (1..2).
REQ-005 SHALL provide parameter CHECK_BIT, default 0, meaning parity bit present (1) or absent (0).
REQ-006 SHALL provide parameter CHECK_MODE, default "EVEN", meaning parity sense, "EVEN" or "ODD".
REQ-007 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-010 SHALL have port rx_data  output  8  received word, LSB first on line; bits above DATA_BIT-1 read 0.
REQ-011 SHALL have port rx_valid  output  1  one-cycle pulse per completed frame.
REQ-012 SHALL have port parity_err  output  1  parity mismatch on frame flagged by rx_valid.
REQ-013 SHALL have port frame_err  output  1  stop bit sampled low on frame flagged by rx_valid.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer, then a falling-edge detector on the synchronized line.
REQ-015 SHALL implement states IDLE, START, DATA, CHECK, STOP with a baud counter 0..BAUD_CNT_MAX-1, restarted to 0 on every state entry.
REQ-016 IDLE -> START on detected falling edge; baud counter starts at 0 in the cycle following detection.
REQ-017 All bits SHALL be sampled when baud counter == BAUD_CNT_MAX/2 (mid-bit).
REQ-018 START: mid-bit sample high = glitch -> return to IDLE immediately, no outputs change; sample low -> DATA at counter == BAUD_CNT_MAX-1.
REQ-019 DATA: sample stored at rx_data bit position bit_cnt; after bit DATA_BIT-1 completes -> CHECK if CHECK_BIT=1, else STOP.
REQ-020 CHECK: expected bit = ^data for "EVEN", ~^data for "ODD" (matches team transmitter); mismatch latched as parity error.
REQ-021 STOP: each stop bit sampled; any low sample latched as frame error; at mid-bit of final stop bit -> IDLE, enabling back-to-back frames.
REQ-022 rx_valid SHALL pulse exactly one cycle, in the cycle after final stop-bit mid-sample; rx_data, parity_err, frame_err update in that same cycle.
REQ-023 rx_data, parity_err, frame_err SHALL hold until the next rx_valid; partial frames never alter them.
REQ-024 A frame with errors SHALL still produce rx_valid; data is delivered as sampled.
REQ-025 Falling edges outside IDLE SHALL be ignored.
REQ-026 Baud counter SHALL be 16 bits wide; BAUD_CNT_MAX < 65536 required.

Reset
REQ-027 On rst: state IDLE, counters 0, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, synchronizer and edge flops 1.
REQ-028 rst mid-frame SHALL abort immediately; partial frame discarded, no rx_valid generated.

Structure
REQ-029 State encodings (IDLE..STOP) and BAUD_CNT_MAX derivation SHALL live in a shared uart header/package common with uart_tx.
REQ-030 One sub-module SHALL be used: uart_rx_sync (2-flop synchronizer plus falling-edge pulse, reset to idle-high).

Verification (CLK_FREQ=16, BAUD_RATE=1 -> 16 clk/bit)
REQ-031 Frame 0xA5, no parity, 1 stop -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0.
REQ-032 CHECK_BIT=1 EVEN, data 0x03 with parity bit 1 -> rx_valid, rx_data=0x03, parity_err=1; parity bit 0 -> parity_err=0.
REQ-033 Frame 0x3C with stop bit driven low -> rx_valid, rx_data=0x3C, frame_err=1; line high again -> next frame 0x11 received, frame_err=0.
REQ-034 rx low 4 clocks then high -> no rx_valid, state back to IDLE by clock 9 of START.
REQ-035 uart_tx loopback, 0x00 then 0xFF back-to-back -> two rx_valid pulses, data 0x00 then 0xFF, no errors.
REQ-036 rst pulsed during DATA bit 3 -> outputs 0 immediately, no rx_valid; following frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions for uart_rx and uart_tx: frame
//                state encodings and the clocks-per-bit derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame-level states, 3-bit encoding shared by receiver and transmitter.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    // Width of the per-bit baud counter; clocks-per-bit must fit below 2^16.
    localparam int unsigned C_BAUD_CNT_W = 16;

    // Clocks per line bit (BAUD_CNT_MAX).
    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous rx line followed
//                by a falling-edge detector. All flops reset to the idle-high
//                line level so reset never fabricates a start edge.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-high reset
//                rx       - raw asynchronous serial input
//                rx_sync  - synchronized line level
//                rx_fall  - one-cycle pulse on a synchronized high->low edge
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_sync = r_sync;
    assign rx_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Samples each bit at mid-bit, supports 5..8
//                data bits, optional even/odd parity and 1..2 stop bits.
//                Returns to IDLE at the mid-point of the final stop bit so
//                back-to-back frames are accepted.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous active-high reset
//                rx         - asynchronous serial line, idle high
//                rx_data    - received word, unused upper bits read 0
//                rx_valid   - one-cycle pulse per completed frame
//                parity_err - parity mismatch on the flagged frame
//                frame_err  - a stop bit sampled low on the flagged frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BIT   = 8,
    parameter int unsigned STOP_BIT   = 1,
    parameter int unsigned CHECK_BIT  = 0,
    parameter              CHECK_MODE = "EVEN"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned            c_baud_cnt_max = baud_cnt_max(CLK_FREQ, BAUD_RATE);
    localparam logic [C_BAUD_CNT_W-1:0] c_cnt_mid     = C_BAUD_CNT_W'(c_baud_cnt_max / 2);
    localparam logic [C_BAUD_CNT_W-1:0] c_cnt_last    = C_BAUD_CNT_W'(c_baud_cnt_max - 1);
    localparam logic [2:0]             c_bit_last     = 3'(DATA_BIT - 1);
    localparam logic                   c_stop_last    = 1'(STOP_BIT - 1);
    localparam logic                   c_odd          = (CHECK_MODE == "ODD");
    localparam logic                   c_has_parity   = (CHECK_BIT != 0);

    logic w_rx_sync;
    logic w_rx_fall;
    logic w_par_exp;

    uart_state_t             r_state;
    logic [C_BAUD_CNT_W-1:0] r_cnt;
    logic [2:0]              r_bit_cnt;
    logic                    r_stop_cnt;
    logic [7:0]              r_shift;
    logic                    r_perr;
    logic                    r_ferr;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_sync (w_rx_sync),
        .rx_fall (w_rx_fall)
    );

    // Upper shift bits are cleared at frame start, so reducing over all eight
    // bits equals reducing over the DATA_BIT received bits.
    assign w_par_exp = c_odd ? ~^r_shift : ^r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_rx_fall) begin
                        r_state    <= ST_START;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_shift    <= '0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_cnt_mid && w_rx_sync) begin
                        // Start bit not low at mid-bit: treat as a glitch.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_cnt_mid) begin
                        r_shift[r_bit_cnt] <= w_rx_sync;
                    end
                    if (r_cnt == c_cnt_last) begin
                        r_cnt <= '0;
                        if (r_bit_cnt == c_bit_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_has_parity ? ST_CHECK : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (r_cnt == c_cnt_mid) begin
                        r_perr <= w_rx_sync ^ w_par_exp;
                    end
                    if (r_cnt == c_cnt_last) begin
                        r_state <= ST_STOP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_cnt_mid) begin
                        if (r_stop_cnt == c_stop_last) begin
                            // Frame complete: publish results and rearm for the
                            // next start edge during the rest of this stop bit.
                            r_state    <= ST_IDLE;
                            r_cnt      <= '0;
                            rx_valid   <= 1'b1;
                            rx_data    <= r_shift;
                            parity_err <= c_has_parity & r_perr;
                            frame_err  <= r_ferr | ~w_rx_sync;
                        end else begin
                            r_ferr <= r_ferr | ~w_rx_sync;
                            r_cnt  <= r_cnt + 1'b1;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
